// File: rtl/matrix_streamer.sv
// Streams a signed SIZE x SIZE matrix out row-major over a valid/ready handshake.
// Optional running checksum output is enabled with MATRIX_STREAM_CHECKSUM_EN.
module matrix_streamer #(
   parameter  int SIZE      = 253,
   parameter  int WIDTH_BIT = 16,
   localparam int CNT_W     = ($clog2(SIZE) > 0) ? $clog2(SIZE) : 1
) (
   input  logic                          clock,
   input  logic                          nreset,
   input  logic signed [WIDTH_BIT-1:0]   matrixIn [SIZE][SIZE],
   input  logic                          start,
   input  logic                          ready,
   output logic                          valid,
   output logic signed [WIDTH_BIT-1:0]   dataOut,
   output logic                          eol,
   output logic                          last,
   output logic                          busy,
`ifdef MATRIX_STREAM_CHECKSUM_EN
   output logic                          done,
   output logic signed [WIDTH_BIT+2*CNT_W-1:0] checksum
`else
   output logic                          done
`endif
);

   // state  | meaning
   // IDLE   | waiting for start
   // STREAM | presenting matrixIn[row][col], advancing on each valid&ready
   // DONE   | one-cycle done pulse after the final transfer
   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

   state_t           state;
   logic [CNT_W-1:0] row;
   logic [CNT_W-1:0] col;
   logic             at_eol;
   logic             at_last;
   logic             xfer;

   assign at_eol  = (col == LAST_IDX);
   assign at_last = at_eol && (row == LAST_IDX);
   assign xfer    = valid && ready;

   always_comb begin
      dataOut = '0;
      eol     = 1'b0;
      last    = 1'b0;
      if (valid) begin
         dataOut = matrixIn[row][col];
         eol     = at_eol;
         last    = at_last;
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= STREAM;
                  row   <= '0;
                  col   <= '0;
                  valid <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            STREAM: begin
               if (xfer) begin
                  if (at_last) begin
                     state <= DONE;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (at_eol) begin
                     col <= '0;
                     row <= row + CNT_W'(1);
                  end else begin
                     col <= col + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MATRIX_STREAM_CHECKSUM_EN
   // Width covers SIZE*SIZE worst-case elements, so the sum cannot wrap.
   localparam int CSW = WIDTH_BIT + 2*CNT_W;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         checksum <= '0;
      end else if (state == IDLE && start) begin
         checksum <= '0;
      end else if (state == STREAM && xfer) begin
         checksum <= checksum + CSW'(dataOut);
      end
   end
`endif

endmodule
